// File: rtl/sysid_regs_if.sv
// sysid_regs_if: Avalon-MM slave bus bundle for the system-identification
// register block. The master modport drives commands and samples responses;
// the slave modport is the register block's view.
interface sysid_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system-identification slave. Reports build identity
// (ID, timestamp, version, capability word), holds a byte-lane writable
// scratch register and, when built with SYSID_UPTIME_EN, a free-running
// uptime counter read coherently via a low-word read that snapshots the
// upper bits into a shadow. Fixed one-cycle read latency, no waitrequest.
// Optional feature macro: SYSID_UPTIME_EN (uptime counter + HI shadow).
module sysid_regs #(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'd1457125450,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          UPTIME_W  = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  sysid_regs_if.slave  bus
);

  // Elaboration-time guard on the counter width.
  if ((UPTIME_W < 33) || (UPTIME_W > 64)) begin : g_bad_uptime_w
    $error("sysid_regs: UPTIME_W must be in 33..64");
  end

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
  localparam logic [2:0] ADDR_VERSION = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH = 3'd3;
  localparam logic [2:0] ADDR_UP_LO   = 3'd4;
  localparam logic [2:0] ADDR_UP_HI   = 3'd5;
  localparam logic [2:0] ADDR_CAPS    = 3'd6;

  // A read always wins over a concurrent write; the write is then dropped.
  logic w_rd_en;
  logic w_wr_en;
  assign w_rd_en = bus.read;
  assign w_wr_en = bus.write & ~bus.read;

  logic [31:0] r_scratch;
  logic [31:0] r_readdata;
  logic        r_readdatavalid;

  logic [31:0] w_uptime_lo;
  logic [31:0] w_uptime_hi_ext;
  logic        w_uptime_present;
  logic [31:0] w_caps;
  logic [31:0] w_rdata;

`ifdef SYSID_UPTIME_EN
  localparam int HI_W = UPTIME_W - 32;
  localparam logic [UPTIME_W-1:0] UPTIME_ONE = UPTIME_W'(1);

  logic [UPTIME_W-1:0] r_uptime;
  logic [HI_W-1:0]     r_hi_shadow;
  logic [UPTIME_W-1:0] w_uptime_next;

  // Next counter value: a write to LO or HI replaces this cycle's increment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_uptime_next = r_uptime + UPTIME_ONE;
    if (w_wr_en && (bus.address == ADDR_UP_LO)) begin
      w_uptime_next = {{HI_W{1'b0}}, bus.writedata};
    end else if (w_wr_en && (bus.address == ADDR_UP_HI)) begin
      w_uptime_next = {bus.writedata[HI_W-1:0], r_uptime[31:0]};
    end
  end

  // Counter register and the HI shadow captured on every LO read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_uptime    <= '0;
      r_hi_shadow <= '0;
    end else begin
      r_uptime <= w_uptime_next;
      if (w_rd_en && (bus.address == ADDR_UP_LO)) begin
        r_hi_shadow <= r_uptime[UPTIME_W-1:32];
      end
    end
  end

  // Zero-extend the shadow to a full bus word.
  always_comb begin
    w_uptime_hi_ext             = '0;
    w_uptime_hi_ext[HI_W-1:0]   = r_hi_shadow;
  end

  assign w_uptime_lo      = r_uptime[31:0];
  assign w_uptime_present = 1'b1;
`else
  assign w_uptime_lo      = '0;
  assign w_uptime_hi_ext  = '0;
  assign w_uptime_present = 1'b0;
`endif

  assign w_caps = {16'd0, 8'd7, 7'd0, w_uptime_present};

  // Scratch register: each byte lane updates only when its enable is set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= '0;
    end else if (w_wr_en && (bus.address == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) begin
          // NOTE: state is updated with non-blocking assignments so every
          // flop samples pre-edge values regardless of statement order.
          r_scratch[i*8 +: 8] <= bus.writedata[i*8 +: 8];
        end
      end
    end
  end

  // Read-data multiplexer over the register map.
  always_comb begin
    w_rdata = '0;
    unique case (bus.address)
      ADDR_ID:      w_rdata = SYSTEM_ID;
      ADDR_TSTAMP:  w_rdata = TIMESTAMP;
      ADDR_VERSION: w_rdata = VERSION;
      ADDR_SCRATCH: w_rdata = r_scratch;
      ADDR_UP_LO:   w_rdata = w_uptime_lo;
      ADDR_UP_HI:   w_rdata = w_uptime_hi_ext;
      ADDR_CAPS:    w_rdata = w_caps;
      default:      w_rdata = '0;
    endcase
  end

  // Registered read response: data holds between reads, valid is a pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= w_rd_en;
      if (w_rd_en) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: self-checking bench for sysid_regs. A behavioural model
// tracks the uptime counter as "base value plus elapsed cycles since the
// last load" and checks every cycle; table vectors and hand sequences add
// fixed expectations for reset, byte lanes, carries and reset mid-read.
module tb_sysid_regs;

  localparam logic [31:0] SYSTEM_ID = 32'h0000_0000;
  localparam logic [31:0] TIMESTAMP = 32'd1457125450;
  localparam logic [31:0] VERSION   = 32'h0001_0000;
`ifdef SYSID_UPTIME_EN
  localparam bit UP_EN = 1'b1;
`else
  localparam bit UP_EN = 1'b0;
`endif
  localparam logic [31:0] CAPS_EXP = UP_EN ? 32'h0000_0701 : 32'h0000_0700;

  logic clock;
  logic reset_n;
  sysid_regs_if bus ();

  sysid_regs dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (64-bit counter, matching the default UPTIME_W).
  int               cyc;
  longint unsigned  m_base;
  int               m_base_cyc;
  logic [31:0]      m_shadow;
  logic [31:0]      m_scratch;
  logic [31:0]      m_last;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic longint unsigned up_val(input int c);
    return m_base + longint'(c - m_base_cyc);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a,
                                             input longint unsigned v);
    case (a)
      3'd0: return SYSTEM_ID;
      3'd1: return TIMESTAMP;
      3'd2: return VERSION;
      3'd3: return m_scratch;
      3'd4: return UP_EN ? v[31:0] : 32'd0;
      3'd5: return UP_EN ? m_shadow : 32'd0;
      3'd6: return CAPS_EXP;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0; m_base = 0; m_base_cyc = 0;
    m_shadow = 0; m_scratch = 0; m_last = 0;
  endtask

  // One bus cycle: predict, drive, clock, then check valid and data.
  task automatic cyc_op(input logic [2:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input string tag);
    longint unsigned v;
    logic [31:0]     exp_d;
    v     = up_val(cyc);
    exp_d = m_last;
    if (rd) begin
      exp_d = model_read(a, v);
      if (a == 3'd4 && UP_EN) m_shadow = v[63:32];
    end else if (wr) begin
      if (a == 3'd3) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_scratch[i*8 +: 8] = wd[i*8 +: 8];
      end else if (a == 3'd4 && UP_EN) begin
        m_base = {32'd0, wd}; m_base_cyc = cyc + 1;
      end else if (a == 3'd5 && UP_EN) begin
        m_base = {wd, v[31:0]}; m_base_cyc = cyc + 1;
      end
    end
    bus.address = a; bus.read = rd; bus.write = wr;
    bus.writedata = wd; bus.byteenable = be;
    @(posedge clock);
    #1;
    cyc++;
    m_last = exp_d;
    check({tag, " valid"}, 32'(bus.readdatavalid), 32'(rd));
    check({tag, " data"}, bus.readdata, exp_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_op(3'd0, 1'b0, 1'b0, 32'd0, 4'd0, "idle");
  endtask

  task automatic do_reset();
    bus.address = 0; bus.read = 0; bus.write = 0;
    bus.writedata = 0; bus.byteenable = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset valid", 32'(bus.readdatavalid), 32'd0);
    check("reset data", bus.readdata, 32'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0]  a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    do_reset();

    // Reset read-back of the whole map, then scratch byte lanes and a
    // write attempt on the read-only ID register.
    tbl.push_back('{3'd0, 1, 0, 0, 0, 1, SYSTEM_ID});
    tbl.push_back('{3'd1, 1, 0, 0, 0, 1, 32'd1457125450});
    tbl.push_back('{3'd2, 1, 0, 0, 0, 1, 32'h0001_0000});
    tbl.push_back('{3'd3, 1, 0, 0, 0, 1, 32'd0});
    tbl.push_back('{3'd4, 1, 0, 0, 0, 0, 32'd0});
    tbl.push_back('{3'd5, 1, 0, 0, 0, 1, 32'd0});
    tbl.push_back('{3'd6, 1, 0, 0, 0, 1, CAPS_EXP});
    tbl.push_back('{3'd7, 1, 0, 0, 0, 1, 32'd0});
    tbl.push_back('{3'd3, 0, 1, 32'hDEAD_BEEF, 4'b1111, 0, 32'd0});
    tbl.push_back('{3'd3, 0, 1, 32'h0000_0055, 4'b0001, 0, 32'd0});
    tbl.push_back('{3'd3, 1, 0, 0, 0, 1, 32'hDEAD_BE55});
    tbl.push_back('{3'd0, 0, 1, 32'h1234_5678, 4'b1111, 0, 32'd0});
    tbl.push_back('{3'd0, 1, 0, 0, 0, 1, SYSTEM_ID});
    tbl.push_back('{3'd7, 0, 1, 32'hFFFF_FFFF, 4'b1111, 0, 32'd0});
    tbl.push_back('{3'd7, 1, 0, 0, 0, 1, 32'd0});
    tbl.push_back('{3'd3, 1, 0, 0, 0, 1, 32'hDEAD_BE55});

    for (int i = 0; i < tbl.size(); i++) begin
      cyc_op(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].be,
             $sformatf("tbl%0d", i));
      if (tbl[i].chk)
        check($sformatf("tbl%0d fixed", i), bus.readdata, tbl[i].exp);
    end

    // Simultaneous read and write: read served, write dropped.
    cyc_op(3'd3, 0, 1, 32'h0000_1234, 4'b1111, "rw setup");
    cyc_op(3'd3, 1, 1, 32'hFFFF_FFFF, 4'b1111, "rw both");
    check("rw both fixed", bus.readdata, 32'h0000_1234);
    cyc_op(3'd3, 1, 0, 0, 0, "rw after");
    check("rw after fixed", bus.readdata, 32'h0000_1234);

`ifdef SYSID_UPTIME_EN
    // Carry across the 32-bit boundary.
    cyc_op(3'd5, 0, 1, 32'd0, 4'd0, "carry hi0");
    cyc_op(3'd4, 0, 1, 32'hFFFF_FFFE, 4'd0, "carry lo");
    idle(5);
    cyc_op(3'd4, 1, 0, 0, 0, "carry rd lo");
    check("carry lo fixed", bus.readdata, 32'd3);
    cyc_op(3'd5, 1, 0, 0, 0, "carry rd hi");
    check("carry hi fixed", bus.readdata, 32'd1);
    // LO read on the last cycle before the wrap, then on the wrap cycle.
    cyc_op(3'd4, 0, 1, 32'hFFFF_FFFF, 4'd0, "wrap0 ld");
    cyc_op(3'd4, 1, 0, 0, 0, "wrap0 lo");
    check("wrap0 lo fixed", bus.readdata, 32'hFFFF_FFFF);
    cyc_op(3'd5, 1, 0, 0, 0, "wrap0 hi");
    check("wrap0 hi fixed", bus.readdata, 32'd0);
    cyc_op(3'd4, 0, 1, 32'hFFFF_FFFF, 4'd0, "wrap1 ld");
    idle(1);
    cyc_op(3'd4, 1, 0, 0, 0, "wrap1 lo");
    check("wrap1 lo fixed", bus.readdata, 32'd0);
    cyc_op(3'd5, 1, 0, 0, 0, "wrap1 hi");
    check("wrap1 hi fixed", bus.readdata, 32'd1);
    // HI read returns the shadow, not the live counter.
    cyc_op(3'd5, 0, 1, 32'd5, 4'd0, "shadow ld");
    cyc_op(3'd5, 1, 0, 0, 0, "shadow old");
    check("shadow old fixed", bus.readdata, 32'd1);
    cyc_op(3'd4, 1, 0, 0, 0, "shadow lo");
    cyc_op(3'd5, 1, 0, 0, 0, "shadow new");
    check("shadow new fixed", bus.readdata, 32'd5);
`else
    cyc_op(3'd4, 0, 1, 32'hCAFE_F00D, 4'b1111, "noup wr lo");
    cyc_op(3'd4, 1, 0, 0, 0, "noup lo");
    check("noup lo fixed", bus.readdata, 32'd0);
    cyc_op(3'd5, 1, 0, 0, 0, "noup hi");
    check("noup hi fixed", bus.readdata, 32'd0);
    cyc_op(3'd6, 1, 0, 0, 0, "noup caps");
    check("noup caps fixed", bus.readdata, 32'h0000_0700);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             "rand");
    end

    // Asynchronous reset between a read and its response.
    cyc_op(3'd3, 0, 1, 32'hA5A5_A5A5, 4'b1111, "mid setup");
    cyc_op(3'd3, 1, 0, 0, 0, "mid first");
    bus.address = 3'd3; bus.read = 1'b1; bus.write = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid valid drop", 32'(bus.readdatavalid), 32'd0);
    check("mid data clear", bus.readdata, 32'd0);
    @(posedge clock);
    #1;
    check("mid no response", 32'(bus.readdatavalid), 32'd0);
    do_reset();
    cyc_op(3'd3, 1, 0, 0, 0, "post scratch");
    check("post scratch fixed", bus.readdata, 32'd0);
    cyc_op(3'd4, 1, 0, 0, 0, "post uptime");
    check("post uptime fixed", bus.readdata, UP_EN ? 32'd1 : 32'd0);
    cyc_op(3'd5, 1, 0, 0, 0, "post hi");
    check("post hi fixed", bus.readdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_regs.md
# sysid_regs

Parametrised system-identification slave for the Nios II system: an Avalon-MM register block that reports build identity (system ID, build timestamp, version, capability word) and adds a writable scratch register plus an optional free-running uptime counter. The counter is read coherently through a low-word snapshot. It sits on the Nios II data master's interconnect next to the other control slaves. Reads have a fixed latency of one cycle, and the block never asserts waitrequest.

## Interface
Parameters:
- SYSTEM_ID, 32'h0000_0000: value returned at address 0.
- TIMESTAMP, 32'd1457125450: build timestamp (Unix seconds) returned at address 1.
- VERSION, 32'h0001_0000: version word {major[31:24], minor[23:16], patch[15:0]} returned at address 2.
- UPTIME_W, 64: uptime counter width, legal range 33..64.

Ports:
- clock, in, 1: single clock; every flop is in this domain.
- reset_n, in, 1: asynchronous, active-low reset.
- address, in, 3: word address.
- read, in, 1: read strobe.
- write, in, 1: write strobe.
- writedata, in, 32: write data.
- byteenable, in, 4: byte lanes; used only at address 3.
- readdata, out, 32: registered read data.
- readdatavalid, out, 1: high exactly one cycle after an accepted read.

## Operation
Register map (R = read, W = write):
- 0 ID (R): returns SYSTEM_ID.
- 1 TIMESTAMP (R): returns TIMESTAMP.
- 2 VERSION (R): returns VERSION.
- 3 SCRATCH (R/W): resets to 0. Each byte is written only when its byteenable bit is set.
- 4 UPTIME_LO (R/W):
  - Read returns counter[31:0] and, in the same cycle, copies counter[UPTIME_W-1:32] into the HI shadow.
  - Write loads counter[31:0] = writedata and clears the upper bits. byteenable is ignored.
- 5 UPTIME_HI (R/W):
  - Read returns the HI shadow, zero-extended. It does not sample the live counter.
  - Write loads counter[UPTIME_W-1:32] = writedata[UPTIME_W-33:0]. Low bits are unchanged.
- 6 CAPS (R): {16'd0, 8'd7, 7'd0, uptime_present}.
- 7 (R): returns 0. Writes are ignored.

Counter behaviour:
- Increments by 1 every cycle that no counter write is taking effect.
- Wraps from all-ones to 0.

Access rules:
- If read and write are both asserted in one cycle, the read is performed and the write is dropped.
- Writes to read-only addresses have no effect.

## Timing
- Reset values: readdata = 0, readdatavalid = 0, SCRATCH = 0, counter = 0, HI shadow = 0.
- Read latency is 1. A read at cycle N gives readdatavalid = 1 and valid readdata at cycle N+1. Back-to-back reads are allowed every cycle.
- Between reads, readdata holds its last value and readdatavalid = 0.
- UPTIME_LO read at cycle N:
  - Returns the counter value present at cycle N, before that cycle's increment.
  - The shadow captures the upper bits of that same value, so a LO read followed by a HI read gives a coherent 64-bit value across a carry.
- Counter writes:
  - The loaded value appears at N+1.
  - There is no increment in the load cycle; incrementing resumes from the loaded value.
  - A load beats the concurrent increment.
- SCRATCH write at cycle N is readable by a read issued at N+1.
- Reset asserted mid-read:
  - readdatavalid drops to 0 immediately (asynchronous).
  - The pending read response is discarded.
  - All state returns to its reset values.

## Configuration
- SYSID_UPTIME_EN defined:
  - The counter and HI shadow are built.
  - CAPS bit0 = 1.
  - Addresses 4 and 5 behave as described above.
- SYSID_UPTIME_EN undefined:
  - No counter or shadow flops are built.
  - Addresses 4 and 5 read 0 and ignore writes.
  - CAPS bit0 = 0.
  - All other registers are unchanged.

## Test plan
- Reset: hold reset_n = 0, release, then read addresses 0..7. Expect SYSTEM_ID, 1457125450, 32'h0001_0000, 0, small uptime, 0, CAPS = 32'h0000_0701, 0. readdatavalid is high one cycle after each read and never otherwise.
- Scratch byte lanes: write 32'hDEADBEEF with byteenable 4'b1111, then 32'h0000_0055 with 4'b0001. A read returns 32'hDEADBE55. A write to address 0 leaves ID unchanged.
- Uptime carry: write HI = 0, then LO = 32'hFFFF_FFFE, wait 5 cycles, read LO, then HI. Expect LO to be a small value and HI = 1, consistent as one 64-bit value. Also read LO on the exact wrap cycle and check that LO and HI stay coherent.
- Simultaneous read and write at address 3 holding 0x0000_1234 (read and write asserted together, writedata 0xFFFFFFFF): readdata = 0x0000_1234 and SCRATCH is unchanged.
- Asynchronous reset mid-read: assert reset_n low between a read and its response. Expect readdatavalid = 0, then SCRATCH and counter = 0 after release.
- Build without SYSID_UPTIME_EN: addresses 4 and 5 read 0, CAPS = 32'h0000_0700, and a write to address 4 leaves reads at 0.
